// File: rtl/rf_pkg.sv
// Shared constants and queue entry type for the register-file writeback path.
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_fwd_match.sv
// Youngest-match search over the valid queue window for one read operand.
module rf_fwd_match
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]         rd_ptr,
  input  logic [PW:0]           count,
  input  logic [AW-1:0]         addr,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count && addr != '0 && entries[idx].rd == addr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with busy
// scoreboard and operand forwarding. Optional counters: RF_WBQ_STATS_EN.
module rf_writeback_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic [AW-1:0]       rd_a1,
  input  logic [AW-1:0]       rd_a2,
  output logic                fwd_hit1,
  output logic [XLEN-1:0]     fwd_data1,
  output logic                fwd_hit2,
  output logic [XLEN-1:0]     fwd_data2,
  output logic                we_RF,
  output logic [AW-1:0]       A3,
  output logic [XLEN-1:0]     WD3,
  output logic [NUM_REGS-1:0] busy,
  output logic [31:0]         stat_writes,
  output logic [31:0]         stat_full_cycles
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  assign wb_ready = count < CW'(DEPTH);
  // x0 writes complete the handshake but never occupy a slot.
  assign push     = wb_valid && wb_ready && (wb_rd != '0);
  assign pop      = count != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= '{rd: wb_rd, data: wb_data};
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is gated so the write port reads as zero whenever the queue is empty.
  assign we_RF = pop;
  assign A3    = pop ? q[rd_ptr].rd   : '0;
  assign WD3   = pop ? q[rd_ptr].data : '0;

  logic [PW-1:0] slot_age;

  always_comb begin
    busy     = '0;
    slot_age = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot_age = PW'(j) - rd_ptr;
      if (CW'(slot_age) < count) busy[q[j].rd] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  rf_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries(q), .rd_ptr(rd_ptr), .count(count), .addr(rd_a1),
    .hit(fwd_hit1), .data(fwd_data1)
  );

  rf_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries(q), .rd_ptr(rd_ptr), .count(count), .addr(rd_a2),
    .hit(fwd_hit2), .data(fwd_data2)
  );

`ifdef RF_WBQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_writes      <= '0;
      stat_full_cycles <= '0;
    end else begin
      if (pop) stat_writes <= stat_writes + 32'd1;
      if (count == CW'(DEPTH)) stat_full_cycles <= stat_full_cycles + 32'd1;
    end
  end
`else
  assign stat_writes      = '0;
  assign stat_full_cycles = '0;
`endif
endmodule
